// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data/instruction memory responder.
// - state_e       : responder FSM states (1-bit encoding)
// - DEPTH_LOG2_DEF: default log2 of the memory depth in 32-bit words
// - word_index    : byte address -> word index (caller truncates to depth)
// - addr_oob      : byte address lies beyond the memory
// - addr_misalign : byte address is not word aligned
package data_mem_responder_pkg;

  typedef enum logic {
    ST_SERVE = 1'b0,
    ST_LOAD  = 1'b1
  } state_e;

  localparam int unsigned DEPTH_LOG2_DEF = 32'd10;

  function automatic logic [31:0] word_index(input logic [31:0] addr);
    return {2'b00, addr[31:2]};
  endfunction

  function automatic logic addr_oob(input logic [31:0] addr, input int unsigned depth_log2);
    return (addr >> (depth_log2 + 32'd2)) != 32'd0;
  endfunction

  function automatic logic addr_misalign(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/data_mem_responder_ram_1r1w.sv
// Simple dual-port RAM: one synchronous read port, one synchronous write port.
// A read and a write to the same word on the same edge return the old word
// (read-first). The read register only updates on an enabled read, so the
// last read word is held. Contents are never reset, which keeps it
// inferable as block RAM.
// Ports:
//   clk_i                : clock
//   re_i / raddr_i       : read enable / word index
//   rdata_o              : registered read data
//   we_i / waddr_i       : write enable / word index
//   wdata_i              : write data
module data_mem_responder_ram_1r1w #(
  parameter int unsigned DEPTH_LOG2 = 32'd10,
  parameter int unsigned WIDTH      = 32'd32
) (
  input  logic                  clk_i,
  input  logic                  re_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output logic [WIDTH-1:0]      rdata_o,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [WIDTH-1:0]      wdata_i
);

  logic [WIDTH-1:0] mem_q [2**DEPTH_LOG2];
  logic [WIDTH-1:0] rdata_q;

  // Storage write port.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port; samples the array before this edge's write lands.
  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the core's read/write memory interface, with a
// streaming program loader. Fixed 1-cycle read latency.
// Ports:
//   clk, rst_n (synchronous, active-low)
//   r_en/r_addr/r_data      : core read port (r_data registered, held)
//   w_en/w_addr/w_data      : core write port
//   ld_start/ld_valid/ld_last/ld_data/ld_ready/ld_done : program loader
//   busy                    : loading; core accesses are not served
//   err_oob/err_misalign/err_busy : sticky error flags, cleared by reset only
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter logic [31:0] OOB_RDATA  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        r_en,
  input  logic [31:0] r_addr,
  output logic [31:0] r_data,
  input  logic        w_en,
  input  logic [31:0] w_addr,
  input  logic [31:0] w_data,
  input  logic        ld_start,
  input  logic        ld_valid,
  input  logic        ld_last,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  output logic        ld_done,
  output logic        busy,
  output logic        err_oob,
  output logic        err_misalign,
  output logic        err_busy
);

  localparam int unsigned AW = DEPTH_LOG2;
  localparam logic [AW-1:0] PTR_MAX = {AW{1'b1}};

  state_e        state_q;
  logic [AW-1:0] ptr_q;
  logic [AW-1:0] ptr_d;
  logic          ld_ready_q;
  logic          ld_done_q;
  logic          busy_q;
  logic          err_oob_q;
  logic          err_misalign_q;
  logic          err_busy_q;
  // rd_vld_q: a read has been accepted since reset (otherwise r_data is 0).
  // oob_sel_q: the last accepted read was out of range.
  logic          rd_vld_q;
  logic          oob_sel_q;

  logic [AW-1:0] r_idx_s;
  logic [AW-1:0] w_idx_s;
  logic          r_oob_s;
  logic          w_oob_s;
  logic          serve_s;
  logic          xfer_s;
  logic          last_xfer_s;
  logic          ram_re_s;
  logic          ram_we_s;
  logic [AW-1:0] ram_waddr_s;
  logic [31:0]   ram_wdata_s;
  logic [31:0]   ram_rdata_s;

  // Address decode, loader handshake and RAM port muxing.
  always_comb begin
    r_idx_s     = AW'(word_index(r_addr));
    w_idx_s     = AW'(word_index(w_addr));
    r_oob_s     = addr_oob(r_addr, DEPTH_LOG2);
    w_oob_s     = addr_oob(w_addr, DEPTH_LOG2);
    serve_s     = (state_q == ST_SERVE);
    xfer_s      = (state_q == ST_LOAD) && ld_valid && ld_ready_q;
    // The pointer never wraps: the top word always terminates the load.
    last_xfer_s = xfer_s && (ld_last || (ptr_q == PTR_MAX));
    ptr_d       = ptr_q + {{(AW-1){1'b0}}, 1'b1};
    // RAM is never touched on a reset edge so a reset mid-load keeps contents intact.
    ram_re_s    = rst_n && serve_s && r_en && !r_oob_s;
    ram_we_s    = rst_n && (xfer_s || (serve_s && w_en && !w_oob_s));
    ram_waddr_s = serve_s ? w_idx_s : ptr_q;
    ram_wdata_s = serve_s ? w_data : ld_data;
  end

  data_mem_responder_ram_1r1w #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (32'd32)
  ) u_ram (
    .clk_i   (clk),
    .re_i    (ram_re_s),
    .raddr_i (r_idx_s),
    .rdata_o (ram_rdata_s),
    .we_i    (ram_we_s),
    .waddr_i (ram_waddr_s),
    .wdata_i (ram_wdata_s)
  );

  // Responder FSM, load pointer, read-source tracking and sticky error flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_SERVE;
      ptr_q          <= {AW{1'b0}};
      ld_ready_q     <= 1'b0;
      ld_done_q      <= 1'b0;
      busy_q         <= 1'b0;
      err_oob_q      <= 1'b0;
      err_misalign_q <= 1'b0;
      err_busy_q     <= 1'b0;
      rd_vld_q       <= 1'b0;
      oob_sel_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_SERVE: begin
          ld_done_q <= 1'b0;
          if (r_en) begin
            rd_vld_q  <= 1'b1;
            oob_sel_q <= r_oob_s;
            if (r_oob_s) begin
              err_oob_q <= 1'b1;
            end
            if (addr_misalign(r_addr)) begin
              err_misalign_q <= 1'b1;
            end
          end
          if (w_en) begin
            if (w_oob_s) begin
              err_oob_q <= 1'b1;
            end
            if (addr_misalign(w_addr)) begin
              err_misalign_q <= 1'b1;
            end
          end
          if (ld_start) begin
            state_q    <= ST_LOAD;
            ptr_q      <= {AW{1'b0}};
            ld_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        ST_LOAD: begin
          ld_done_q <= 1'b0;
          if (r_en || w_en) begin
            err_busy_q <= 1'b1;
          end
          if (last_xfer_s) begin
            state_q    <= ST_SERVE;
            ld_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            ld_done_q  <= 1'b1;
          end else if (xfer_s) begin
            ptr_q <= ptr_d;
          end
        end
        default: begin
          state_q    <= ST_SERVE;
          ld_ready_q <= 1'b0;
          busy_q     <= 1'b0;
          ld_done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Every source of r_data is a flop; the mux only picks which one.
  assign r_data       = !rd_vld_q ? 32'h0000_0000 : (oob_sel_q ? OOB_RDATA : ram_rdata_s);
  assign ld_ready     = ld_ready_q;
  assign ld_done      = ld_done_q;
  assign busy         = busy_q;
  assign err_oob      = err_oob_q;
  assign err_misalign = err_misalign_q;
  assign err_busy     = err_busy_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (DEPTH_LOG2=10, OOB_RDATA=0).
module tb_data_mem_responder;

  logic        clk;
  logic        rst_n;
  logic        r_en;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic        w_en;
  logic [31:0] w_addr;
  logic [31:0] w_data;
  logic        ld_start;
  logic        ld_valid;
  logic        ld_last;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic        ld_done;
  logic        busy;
  logic        err_oob;
  logic        err_misalign;
  logic        err_busy;

  int pass_cnt;
  int total_cnt;

  data_mem_responder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .r_en         (r_en),
    .r_addr       (r_addr),
    .r_data       (r_data),
    .w_en         (w_en),
    .w_addr       (w_addr),
    .w_data       (w_data),
    .ld_start     (ld_start),
    .ld_valid     (ld_valid),
    .ld_last      (ld_last),
    .ld_data      (ld_data),
    .ld_ready     (ld_ready),
    .ld_done      (ld_done),
    .busy         (busy),
    .err_oob      (err_oob),
    .err_misalign (err_misalign),
    .err_busy     (err_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    r_en = 1'b0; r_addr = 32'h0; w_en = 1'b0; w_addr = 32'h0; w_data = 32'h0;
    ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = 32'h0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    w_en = 1'b1; w_addr = a; w_data = d;
    tick();
    w_en = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a);
    r_en = 1'b1; r_addr = a;
    tick();
    r_en = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick(); tick();
    total_cnt++;
    if ({r_data, ld_ready, ld_done, busy, err_oob, err_misalign, err_busy} !== {32'h0, 6'b000000})
      $display("FAIL reset_state: r_data=%h rdy=%b done=%b busy=%b errs=%b%b%b expected all 0",
               r_data, ld_ready, ld_done, busy, err_oob, err_misalign, err_busy);
    else pass_cnt++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    do_write(32'h10, 32'hDEAD_BEEF);
    do_read(32'h10);
    total_cnt++;
    if (r_data !== 32'hDEAD_BEEF) $display("FAIL wr_rd: r_data=%h expected DEADBEEF", r_data);
    else pass_cnt++;
    tick(); tick();
    total_cnt++;
    if (r_data !== 32'hDEAD_BEEF) $display("FAIL wr_rd_hold: r_data=%h expected DEADBEEF", r_data);
    else pass_cnt++;
  endtask

  task automatic test_read_first();
    do_write(32'h20, 32'h1);
    r_en = 1'b1; r_addr = 32'h20;
    w_en = 1'b1; w_addr = 32'h20; w_data = 32'h2;
    tick();
    r_en = 1'b0; w_en = 1'b0;
    total_cnt++;
    if (r_data !== 32'h1) $display("FAIL read_first_old: r_data=%h expected 00000001", r_data);
    else pass_cnt++;
    do_read(32'h20);
    total_cnt++;
    if (r_data !== 32'h2) $display("FAIL read_first_new: r_data=%h expected 00000002", r_data);
    else pass_cnt++;
  endtask

  task automatic test_busy();
    do_write(32'h24, 32'h77);
    do_read(32'h10);
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    total_cnt++;
    if ({ld_ready, busy} !== 2'b11) $display("FAIL busy_enter: rdy=%b busy=%b expected 1 1", ld_ready, busy);
    else pass_cnt++;
    r_en = 1'b1; r_addr = 32'h24;
    w_en = 1'b1; w_addr = 32'h24; w_data = 32'h99;
    tick();
    r_en = 1'b0; w_en = 1'b0;
    total_cnt++;
    if (r_data !== 32'hDEAD_BEEF || err_busy !== 1'b1)
      $display("FAIL busy_access: r_data=%h err_busy=%b expected DEADBEEF 1", r_data, err_busy);
    else pass_cnt++;
    ld_valid = 1'b1; ld_last = 1'b1; ld_data = 32'h11;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    do_read(32'h24);
    total_cnt++;
    if (r_data !== 32'h77) $display("FAIL busy_write_dropped: r_data=%h expected 00000077", r_data);
    else pass_cnt++;
  endtask

  task automatic test_load();
    int done_pulses;
    done_pulses = 0;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b0;
      tick();
      if (ld_done === 1'b1) done_pulses++;
      ld_valid = 1'b1; ld_data = 32'hA0 + i; ld_last = (i == 3);
      tick();
      if (ld_done === 1'b1) done_pulses++;
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    total_cnt++;
    if ({ld_done, busy, ld_ready} !== 3'b100)
      $display("FAIL load_end: done=%b busy=%b rdy=%b expected 1 0 0", ld_done, busy, ld_ready);
    else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (ld_done === 1'b1) done_pulses++;
    end
    total_cnt++;
    if (done_pulses !== 1) $display("FAIL load_done_once: pulses=%0d expected 1", done_pulses);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      do_read(32'(i * 4));
      total_cnt++;
      if (r_data !== 32'(32'hA0 + i)) $display("FAIL load_word%0d: r_data=%h expected %h", i, r_data, 32'hA0 + i);
      else pass_cnt++;
    end
  endtask

  task automatic test_errors();
    do_read(32'h0000_1000);
    total_cnt++;
    if (r_data !== 32'h0 || err_oob !== 1'b1)
      $display("FAIL oob_read: r_data=%h err_oob=%b expected 00000000 1", r_data, err_oob);
    else pass_cnt++;
    do_read(32'h13);
    total_cnt++;
    if (r_data !== 32'hDEAD_BEEF || err_misalign !== 1'b1)
      $display("FAIL misalign_read: r_data=%h err_mis=%b expected DEADBEEF 1", r_data, err_misalign);
    else pass_cnt++;
    do_read(32'h20);
    tick(); tick();
    total_cnt++;
    if ({err_oob, err_misalign, err_busy} !== 3'b111)
      $display("FAIL sticky_flags: errs=%b%b%b expected 111", err_oob, err_misalign, err_busy);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_load();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b1; ld_data = 32'hB0;
    tick();
    ld_data = 32'hB1;
    tick();
    ld_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total_cnt++;
    if ({ld_ready, busy, ld_done, err_oob, err_misalign, err_busy} !== 6'b000000)
      $display("FAIL midload_reset: rdy=%b busy=%b done=%b errs=%b%b%b expected all 0",
               ld_ready, busy, ld_done, err_oob, err_misalign, err_busy);
    else pass_cnt++;
    do_read(32'h0);
    total_cnt++;
    if (r_data !== 32'hB0) $display("FAIL midload_keep0: r_data=%h expected 000000B0", r_data);
    else pass_cnt++;
    do_read(32'h4);
    total_cnt++;
    if (r_data !== 32'hB1) $display("FAIL midload_keep1: r_data=%h expected 000000B1", r_data);
    else pass_cnt++;
    do_read(32'h8);
    total_cnt++;
    if (r_data !== 32'hA2) $display("FAIL midload_keep2: r_data=%h expected 000000A2", r_data);
    else pass_cnt++;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b1; ld_last = 1'b1; ld_data = 32'hC0;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    do_read(32'h0);
    total_cnt++;
    if (r_data !== 32'hC0) $display("FAIL restart_word0: r_data=%h expected 000000C0", r_data);
    else pass_cnt++;
    do_read(32'h4);
    total_cnt++;
    if (r_data !== 32'hB1) $display("FAIL restart_word1: r_data=%h expected 000000B1", r_data);
    else pass_cnt++;
  endtask

  task automatic test_full_load();
    int done_at;
    done_at = -1;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b1; ld_last = 1'b0;
    for (int i = 0; i < 1030; i++) begin
      ld_data = 32'h1000 + 32'(i);
      tick();
      if (ld_done === 1'b1 && done_at < 0) done_at = i;
    end
    ld_valid = 1'b0;
    total_cnt++;
    if (done_at !== 1023 || busy !== 1'b0)
      $display("FAIL full_load_end: done_at=%0d busy=%b expected 1023 0", done_at, busy);
    else pass_cnt++;
    do_read(32'hFFC);
    total_cnt++;
    if (r_data !== 32'h13FF) $display("FAIL full_load_top: r_data=%h expected 000013FF", r_data);
    else pass_cnt++;
    do_read(32'h0);
    total_cnt++;
    if (r_data !== 32'h1000) $display("FAIL full_load_nowrap: r_data=%h expected 00001000", r_data);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst_n     = 1'b0;
    idle_inputs();
    test_reset();
    test_write_read();
    test_read_first();
    test_busy();
    test_load();
    test_errors();
    test_reset_mid_load();
    test_full_load();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
